// File: rtl/edge_stats_pkg.sv
// Shared widths and pixel constants for the edge-threshold statistics block.
package edge_stats_pkg;

  localparam int DATA_W_DEF  = 12;
  localparam int COORD_W_DEF = 11;
  localparam int CNT_W_DEF   = 20;

  // Single-bit fill values, replicated to the pixel width at the point of use.
  localparam bit PIX_ON  = 1'b1;
  localparam bit PIX_OFF = 1'b0;

endpackage

// File: rtl/edge_frame_counter.sv
// Saturating per-frame edge counter; latches the finished frame's total and strobes done.
module edge_frame_counter
  import edge_stats_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             frame_new_i,
  output logic [CNT_W-1:0] count_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d   = cnt_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (frame_new_i) begin
      // The wrap pixel opens the new frame, so it seeds the fresh count.
      count_d = cnt_q;
      cnt_d   = inc_i ? CNT_W'(1) : '0;
      done_d  = 1'b1;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = done_q;

endmodule

// File: rtl/edge_threshold_stats.sv
// Binarises the edge-magnitude stream with a per-frame threshold and horizontal
// hysteresis, drives identical RGB outputs and reports edge pixels per frame.
module edge_threshold_stats
  import edge_stats_pkg::*;
#(
  parameter int                DATA_W         = DATA_W_DEF,
  parameter int                COORD_W        = COORD_W_DEF,
  parameter int                CNT_W          = CNT_W_DEF,
  parameter logic [DATA_W-1:0] DEFAULT_THRESH = DATA_W'(256),
  parameter logic [DATA_W-1:0] HYST           = DATA_W'(64)
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [DATA_W-1:0]  iDATA,
  input  logic               iDVAL,
  input  logic [COORD_W-1:0] iX_Cont,
  input  logic [COORD_W-1:0] iY_Cont,
  input  logic [DATA_W-1:0]  iThreshold,
  input  logic               iEnable,
  output logic [DATA_W-1:0]  oRed,
  output logic [DATA_W-1:0]  oGreen,
  output logic [DATA_W-1:0]  oBlue,
  output logic               oDVAL,
  output logic [CNT_W-1:0]   oEdgeCount,
  output logic               oFrameDone
);

  logic [COORD_W-1:0] y_prev_q;
  logic [DATA_W-1:0]  thr_q, thr_d;
  logic [DATA_W-1:0]  data_q;
  logic               dval_q, line_new_q, frame_new_q, strong_q, weak_q;
  logic               prev_edge_q, prev_edge_d;
  logic [DATA_W-1:0]  pix_q, pix_d;
  logic               odval_q;

  logic               frame_new, line_new, edge_px;
  logic [DATA_W-1:0]  thr_eff, thr_lo;

  // Column position is not needed: line and frame boundaries come from the row counter.
  logic x_unused;
  assign x_unused = ^iX_Cont;

  always_comb begin
    frame_new = (iY_Cont < y_prev_q);
    line_new  = (iY_Cont != y_prev_q);
    // The wrap pixel already uses the newly requested threshold.
    thr_eff   = frame_new ? iThreshold : thr_q;
    thr_lo    = (thr_eff >= HYST) ? (thr_eff - HYST) : '0;
    thr_d     = frame_new ? iThreshold : thr_q;

    // Weak pixels only extend an edge run within the same line.
    edge_px     = strong_q | (weak_q & prev_edge_q & ~line_new_q);
    prev_edge_d = line_new_q ? 1'b0 : (dval_q ? edge_px : prev_edge_q);
    pix_d       = iEnable ? (edge_px ? {DATA_W{PIX_ON}} : {DATA_W{PIX_OFF}}) : data_q;
  end

  // NOTE: every register, including the threshold shadow, is cleared by the async reset so a mid-frame reset leaves no stale state.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      y_prev_q    <= '0;
      thr_q       <= DEFAULT_THRESH;
      data_q      <= '0;
      dval_q      <= 1'b0;
      line_new_q  <= 1'b0;
      frame_new_q <= 1'b0;
      strong_q    <= 1'b0;
      weak_q      <= 1'b0;
      prev_edge_q <= 1'b0;
      pix_q       <= '0;
      odval_q     <= 1'b0;
    end else begin
      y_prev_q    <= iY_Cont;
      thr_q       <= thr_d;
      data_q      <= iDATA;
      dval_q      <= iDVAL;
      line_new_q  <= line_new;
      frame_new_q <= frame_new;
      strong_q    <= (iDATA >= thr_eff);
      weak_q      <= (iDATA >= thr_lo);
      prev_edge_q <= prev_edge_d;
      pix_q       <= pix_d;
      odval_q     <= dval_q;
    end
  end

  edge_frame_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk         (iCLK),
    .rst_n       (iRST),
    .inc_i       (dval_q & edge_px),
    .frame_new_i (frame_new_q),
    .count_o     (oEdgeCount),
    .done_o      (oFrameDone)
  );

  assign oRed   = pix_q;
  assign oGreen = pix_q;
  assign oBlue  = pix_q;
  assign oDVAL  = odval_q;

endmodule

// File: tb/tb_edge_threshold_stats.sv
// Directed bench for edge_threshold_stats: thresholding, hysteresis, frame counting, saturation, reset.
module tb_edge_threshold_stats;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [11:0] iDATA;
  logic        iDVAL;
  logic [10:0] iX_Cont;
  logic [10:0] iY_Cont;
  logic [11:0] iThreshold;
  logic        iEnable;

  logic [11:0] oRed, oGreen, oBlue;
  logic        oDVAL, oFrameDone;
  logic [19:0] oEdgeCount;

  logic [11:0] s_red, s_green, s_blue;
  logic        s_dval, s_done;
  logic [3:0]  s_count;

  int   total = 0;
  int   bad   = 0;
  logic prev_v = 1'b0;
  logic [10:0] x_cnt = '0;

  always #5 iCLK = ~iCLK;

  edge_threshold_stats dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iDATA      (iDATA),
    .iDVAL      (iDVAL),
    .iX_Cont    (iX_Cont),
    .iY_Cont    (iY_Cont),
    .iThreshold (iThreshold),
    .iEnable    (iEnable),
    .oRed       (oRed),
    .oGreen     (oGreen),
    .oBlue      (oBlue),
    .oDVAL      (oDVAL),
    .oEdgeCount (oEdgeCount),
    .oFrameDone (oFrameDone)
  );

  edge_threshold_stats #(.CNT_W(4)) dut_s (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iDATA      (iDATA),
    .iDVAL      (iDVAL),
    .iX_Cont    (iX_Cont),
    .iY_Cont    (iY_Cont),
    .iThreshold (iThreshold),
    .iEnable    (iEnable),
    .oRed       (s_red),
    .oGreen     (s_green),
    .oBlue      (s_blue),
    .oDVAL      (s_dval),
    .oEdgeCount (s_count),
    .oFrameDone (s_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one input cycle, then checks the output produced by the previous cycle's pixel.
  task automatic step(input logic [10:0] y, input logic [11:0] d, input logic v,
                      input logic [11:0] exp_prev, input string tag);
    iY_Cont = y;
    iDATA   = d;
    iDVAL   = v;
    iX_Cont = x_cnt;
    x_cnt   = x_cnt + 11'd1;
    @(posedge iCLK);
    #1;
    check({tag, "_dval"}, {31'd0, oDVAL}, {31'd0, prev_v});
    if (prev_v) check({tag, "_pix"}, {20'd0, oRed}, {20'd0, exp_prev});
    prev_v = v;
  endtask

  initial begin
    // Reset held with toggling inputs: all outputs stay 0.
    iRST = 1'b0; iEnable = 1'b1; iThreshold = 12'd1000;
    iDATA = '0; iDVAL = 1'b0; iX_Cont = '0; iY_Cont = '0;
    for (int i = 0; i < 4; i++) begin
      iDATA   = 12'($urandom_range(0, 4095));
      iDVAL   = ~iDVAL;
      iY_Cont = 11'($urandom_range(0, 479));
      @(posedge iCLK);
      #1;
      check("rst_out", {8'd0, oRed, oGreen}, 32'd0);
      check("rst_misc", {10'd0, oBlue, oDVAL, oFrameDone, 8'd0}, 32'd0);
      check("rst_cnt", {12'd0, oEdgeCount}, 32'd0);
    end
    iY_Cont = '0; iDVAL = 1'b0; iDATA = '0;
    iRST = 1'b1;

    step(0, 0, 0, 0, "idle0");
    // Threshold probe: 256 after reset (iThreshold=1000 is not taken without a frame wrap).
    step(1, 255,  1, 0,       "probe");
    step(1, 256,  1, 12'h000, "p255");
    step(1, 0,    0, 12'hFFF, "p256");
    check("cnt_noframe", {12'd0, oEdgeCount}, 32'd0);

    // One row with hysteresis.
    step(2, 100, 1, 0,       "row2");
    step(2, 300, 1, 12'h000, "r100");
    step(2, 250, 1, 12'hFFF, "r300");
    step(2, 200, 1, 12'hFFF, "r250");
    step(2, 150, 1, 12'hFFF, "r200");
    check("green", {20'd0, oGreen}, 32'hFFF);
    check("blue",  {20'd0, oBlue},  32'hFFF);
    step(2, 0,   0, 12'h000, "r150");

    // Row ends on an edge; next row's weak pixel must not inherit it.
    step(3, 300, 1, 0,       "row3");
    step(3, 0,   0, 12'hFFF, "r3_300");
    step(4, 200, 1, 0,       "row4");
    step(4, 0,   0, 12'h000, "r4_200");

    // Mid-frame threshold change is ignored until the wrap.
    iThreshold = 12'd4000;
    step(4, 300, 1, 0,       "mid");
    step(4, 0,   0, 12'hFFF, "mid300");
    check("done_mid", {31'd0, oFrameDone}, 32'd0);
    check("cnt_mid", {12'd0, oEdgeCount}, 32'd0);

    // Wrap 4 -> 0: frame of 6 edge pixels published; wrap pixel uses 4000.
    step(0, 300, 1, 0,       "wrap1");
    step(0, 0,   0, 12'h000, "wrap1_300");
    check("done_wrap1", {31'd0, oFrameDone}, 32'd1);
    check("cnt_wrap1", {12'd0, oEdgeCount}, 32'd6);
    check("scnt_wrap1", {28'd0, s_count}, 32'd6);
    step(0, 4000, 1, 0,       "f2a");
    check("done_pulse", {31'd0, oFrameDone}, 32'd0);
    step(0, 0,    0, 12'hFFF, "f2_4000");

    // Saturation: 21 edge pixels in this frame, 4-bit counter clips at 15.
    for (int i = 0; i < 20; i++) step(1, 4095, 1, 12'hFFF, "sat");
    iThreshold = 12'd256;
    step(0, 0, 1, 12'hFFF, "wrap2");
    step(0, 0, 0, 12'h000, "wrap2_0");
    check("done_wrap2", {31'd0, oFrameDone}, 32'd1);
    check("cnt_wrap2", {12'd0, oEdgeCount}, 32'd21);
    check("scnt_sat", {28'd0, s_count}, 32'd15);

    // Pass-through mode, then async reset mid-frame.
    iEnable = 1'b0;
    step(0, 300, 1, 0,      "pass");
    step(0, 777, 1, 12'd300, "pass300");
    check("pass_grn", {20'd0, oGreen}, 32'd300);
    #2;
    iRST = 1'b0;
    #1;
    check("arst_pix", {20'd0, oRed}, 32'd0);
    check("arst_dval", {31'd0, oDVAL}, 32'd0);
    check("arst_cnt", {12'd0, oEdgeCount}, 32'd0);
    #1;
    iRST = 1'b1; prev_v = 1'b0; iEnable = 1'b1;
    step(5, 300, 1, 0,       "post");
    step(5, 300, 1, 12'hFFF, "post_a");
    step(5, 0,   0, 12'hFFF, "post_b");
    step(0, 0,   1, 0,       "wrap3");
    step(0, 0,   0, 12'h000, "wrap3_0");
    check("done_wrap3", {31'd0, oFrameDone}, 32'd1);
    check("cnt_wrap3", {12'd0, oEdgeCount}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
